// File: rtl/vme_mem_master.sv
// Single-outstanding command master for the VME memory strobe bus.
// Issues one strobe per command and returns data or a timeout error.
module vme_mem_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] VMEAddr,
  output logic [31:0]           VMEWrData,
  output logic                  VMERdMem,
  output logic                  VMEWrMem,
  input  logic [31:0]           VMERdData,
  input  logic                  VMERdDone,
  input  logic                  VMEWrDone,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic          we_q;
  logic [CW-1:0] cnt;
  logic          done_hit;

  assign done_hit  = we_q ? VMEWrDone : VMERdDone;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      cnt       <= '0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            we_q      <= cmd_we;
            VMEAddr   <= cmd_addr;
            VMEWrData <= cmd_we ? cmd_wdata : 32'h0;
            VMERdMem  <= ~cmd_we;
            VMEWrMem  <= cmd_we;
            cnt       <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // a done on the final timeout cycle still counts as success
          if (done_hit) begin
            rsp_rdata <= we_q ? 32'h0 : VMERdData;
            rsp_err   <= 1'b0;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            state     <= RESP;
          end else if (state == WAIT && cnt == TMAX) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b1;
            VMEAddr   <= '0;
            VMEWrData <= '0;
            state     <= RESP;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= WAIT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_mem_master.sv
// Bench for vme_mem_master: directed table, random transactions
// against a latency/response model, and a mid-transaction reset.
module tb_vme_mem_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem;
  logic        VMEWrMem;
  logic [31:0] VMERdData = '0;
  logic        VMERdDone = 1'b0;
  logic        VMEWrDone = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  vme_mem_master #(.ADDR_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone),
    .VMEWrDone(VMEWrDone), .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          dk;
    int          sk;
    logic [31:0] sd;
    int          hold;
    logic        keep;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;

  int total = 0;
  int passed = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    cmd_valid = 0; rsp_ready = 0;
    VMERdDone = 0; VMEWrDone = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // response timing measured in cycles after the strobe cycle
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.dk >= 0 && v.dk <= TO) begin
      r.e_lat = v.dk + 1;
      r.e_err = 1'b0;
      r.e_rd  = v.we ? 32'h0 : v.sd;
    end else begin
      r.e_lat = TO + 1;
      r.e_err = 1'b1;
      r.e_rd  = 32'h0;
    end
    return r;
  endfunction

  task automatic run(input vec_t v);
    int lat = -1;
    int nrd = 0;
    int nwr = 0;
    logic bad = 1'b0;
    logic [31:0] rd0;
    logic er0;
    check("idle_ready", {31'b0, cmd_ready}, 1);
    cmd_valid = 1; cmd_we = v.we;
    cmd_addr = v.addr; cmd_wdata = v.wd;
    @(negedge clk);
    if (!v.keep) cmd_valid = 0;
    for (int j = 0; j < 16; j++) begin
      if (rsp_valid) begin
        lat = j;
        break;
      end
      nrd += int'(VMERdMem);
      nwr += int'(VMEWrMem);
      if (VMEAddr !== v.addr) bad = 1;
      if (VMEWrData !== (v.we ? v.wd : 32'h0)) bad = 1;
      if (!busy || cmd_ready) bad = 1;
      VMERdDone = v.we ? (j == v.sk) : (j == v.dk);
      VMEWrDone = v.we ? (j == v.dk) : (j == v.sk);
      VMERdData = (j == v.dk) ? v.sd : $urandom;
      @(negedge clk);
    end
    VMERdDone = 0; VMEWrDone = 0;
    check("rsp_latency", lat, v.e_lat);
    check("rd_strobes", nrd, {31'b0, ~v.we});
    check("wr_strobes", nwr, {31'b0, v.we});
    check("bus_hold", {31'b0, bad}, 0);
    if (lat < 0) begin
      do_reset();
      return;
    end
    check("rsp_rdata", rsp_rdata, v.e_rd);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, v.e_err});
    rd0 = rsp_rdata; er0 = rsp_err; bad = 0;
    for (int h = 0; h < v.hold; h++) begin
      VMERdDone = 1'($urandom);
      VMEWrDone = 1'($urandom);
      @(negedge clk);
      if (!rsp_valid || cmd_ready) bad = 1;
      if (rsp_rdata !== rd0 || rsp_err !== er0) bad = 1;
      if (VMERdMem || VMEWrMem) bad = 1;
    end
    if (v.hold > 0) check("rsp_stable", {31'b0, bad}, 0);
    VMERdDone = 0; VMEWrDone = 0;
    cmd_valid = 0; rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("post_idle", {29'b0, rsp_valid, cmd_ready, busy},
          32'b010);
  endtask

  vec_t tbl[7];
  vec_t rv;
  logic flag;

  initial begin
    tbl[0] = '{we:0, addr:8'h04, wd:32'h0, dk:1, sk:-1,
               sd:32'h0000BEEF, hold:0, keep:0,
               e_lat:2, e_err:0, e_rd:32'h0000BEEF};
    tbl[1] = '{we:1, addr:8'h00, wd:32'h12345678, dk:2, sk:-1,
               sd:32'hDEAD0000, hold:1, keep:0,
               e_lat:3, e_err:0, e_rd:32'h0};
    tbl[2] = '{we:0, addr:8'h10, wd:32'h0, dk:-1, sk:-1,
               sd:32'h11111111, hold:0, keep:0,
               e_lat:5, e_err:1, e_rd:32'h0};
    tbl[3] = '{we:0, addr:8'h11, wd:32'h0, dk:4, sk:-1,
               sd:32'hCAFEF00D, hold:0, keep:0,
               e_lat:5, e_err:0, e_rd:32'hCAFEF00D};
    tbl[4] = '{we:0, addr:8'h22, wd:32'h0, dk:3, sk:1,
               sd:32'hA5A5A5A5, hold:0, keep:0,
               e_lat:4, e_err:0, e_rd:32'hA5A5A5A5};
    tbl[5] = '{we:1, addr:8'hFF, wd:32'hFFFF0001, dk:0, sk:-1,
               sd:32'h0, hold:10, keep:1,
               e_lat:1, e_err:0, e_rd:32'h0};
    tbl[6] = '{we:1, addr:8'h5A, wd:32'h0BADC0DE, dk:5, sk:2,
               sd:32'h0, hold:2, keep:0,
               e_lat:5, e_err:1, e_rd:32'h0};

    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_ready", {31'b0, cmd_ready}, 1);
    check("rst_busy_valid", {30'b0, busy, rsp_valid}, 0);
    check("rst_rsp", {rsp_rdata[30:0], rsp_err}, 0);
    check("rst_bus", {VMEWrData[21:0], VMEAddr,
                      VMERdMem, VMEWrMem}, 0);

    for (int i = 0; i < 7; i++) run(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      rv.we   = 1'($urandom);
      rv.addr = 8'($urandom);
      rv.wd   = $urandom;
      rv.dk   = int'($urandom_range(0, 7)) - 1;
      rv.sk   = int'($urandom_range(0, 7)) - 1;
      rv.sd   = $urandom;
      rv.hold = int'($urandom_range(0, 3));
      rv.keep = 1'($urandom);
      run(model(rv));
    end

    // reset in WAIT, then a late done must be ignored
    cmd_valid = 1; cmd_we = 0; cmd_addr = 8'h33;
    @(negedge clk);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("abort_bus", {VMEAddr, busy, cmd_ready}, 32'b01);
    VMERdDone = 1; VMERdData = 32'h77777777;
    @(negedge clk);
    VMERdDone = 0;
    flag = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid || VMERdMem || VMEWrMem || busy) flag = 1;
      @(negedge clk);
    end
    check("abort_quiet", {31'b0, flag}, 0);
    check("abort_ready", {31'b0, cmd_ready}, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vme_mem_master.md
VME_MEM_MASTER -- requirements
Module: vme_mem_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, width of the memory-bus word address.
REQ-002 SHALL have parameter TIMEOUT, default 255, legal range 1..65535; max cycles after the strobe to wait for a done.
REQ-003 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_we  in  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  in  ADDR_WIDTH  target address.
REQ-009 SHALL have port cmd_wdata  in  32  write data.
REQ-010 SHALL have port rsp_valid  out  1  response available.
REQ-011 SHALL have port rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high.
REQ-012 SHALL have port rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_err  out  1  1=timeout.
REQ-014 SHALL have port VMEAddr  out  ADDR_WIDTH  bus address.
REQ-015 SHALL have port VMEWrData  out  32  bus write data.
REQ-016 SHALL have port VMERdMem  out  1  one-cycle read strobe.
REQ-017 SHALL have port VMEWrMem  out  1  one-cycle write strobe.
REQ-018 SHALL have port VMERdData  in  32  slave read data, valid with VMERdDone.
REQ-019 SHALL have port VMERdDone  in  1  read completion pulse.
REQ-020 SHALL have port VMEWrDone  in  1  write completion pulse.
REQ-021 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-022 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered or decoded from state only.
REQ-023 cmd_ready SHALL be 1 only in IDLE; on accept, cmd_we/addr/wdata are captured and the state goes to ISSUE.
REQ-024 In ISSUE: exactly one of VMERdMem/VMEWrMem (per captured we) high for exactly one cycle; timeout counter cleared; next state WAIT unless a matching done is sampled in the same cycle.
REQ-025 VMEAddr and VMEWrData SHALL hold the captured values from ISSUE until leaving WAIT; VMEWrData SHALL be 0 for reads.
REQ-026 Matching done: VMERdDone for reads, VMEWrDone for writes; the non-matching done, and any done in IDLE or RESP, SHALL be ignored.
REQ-027 On a matching done in ISSUE or WAIT: rsp_rdata = VMERdData (read) or 0 (write), rsp_err = 0, next state RESP.
REQ-028 WAIT: counter increments each cycle without a done; if no done by strobe cycle + TIMEOUT, next state RESP with rsp_err = 1, rsp_rdata = 0.
REQ-029 A done arriving in the same cycle the timeout expires SHALL win: treat as success.
REQ-030 RESP: rsp_valid = 1, response held stable until rsp_ready; on handshake go to IDLE; cmd_ready = 1 on the following cycle.
REQ-031 Latency: accept at cycle T, strobe at T+1; with a slave done at strobe+k, rsp_valid SHALL rise at T+2+k.
REQ-032 Counter width SHALL be sized to hold TIMEOUT without wrap.
REQ-033 At most one transaction outstanding; no command buffering beyond the capture registers.

Reset
REQ-034 While rst_n = 0 at a clock edge: state IDLE, cmd_ready = 1 after release, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, VMERdMem = VMEWrMem = 0, VMEAddr = 0, VMEWrData = 0, busy = 0, counter = 0.
REQ-035 Reset asserted mid-transaction SHALL abort it with no response; a done arriving after reset SHALL be ignored.

Verification
REQ-036 Read, addr 0x04, slave returns 0x0000BEEF with done at strobe+1 -> one VMERdMem pulse, rsp_valid at T+3, rsp_rdata = 0x0000BEEF, rsp_err = 0.
REQ-037 Write, addr 0x00, data 0x12345678, slave done at strobe+2 -> one VMEWrMem pulse, VMEWrData = 0x12345678 held until done, rsp_rdata = 0, rsp_err = 0.
REQ-038 TIMEOUT = 4, read with no done -> rsp_valid at strobe+5, rsp_err = 1, rsp_rdata = 0; done at strobe+4 instead -> rsp_err = 0.
REQ-039 Read with a stray VMEWrDone at strobe+1 and VMERdDone at strobe+3 -> stray ignored, response at strobe+4 with the read data.
REQ-040 rsp_ready held low for 10 cycles with cmd_valid high -> response stable, cmd_ready = 0, no new strobe until the handshake.
REQ-041 rst_n low in WAIT, then a done pulse -> no rsp_valid, strobes 0, cmd_ready = 1 after release.
